// File: rtl/ppc_types.sv
// ppc_types: shared PowerPC decode types used by the branch issue path.
//   branch_op_t           - branch flavour (immediate, conditional, to LR, to CTR)
//   branch_inner_decode_t - decoded branch fields handed from decode to the predictor
package ppc_types;
    typedef enum logic [1:0] {BR_IMM, BR_COND, BR_LR, BR_CTR} branch_op_t;
    typedef struct packed {
        branch_op_t  op;
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [23:0] target;
        logic        aa;
        logic        lk;
    } branch_inner_decode_t;
endpackage

// File: rtl/spr_tag_entry.sv
// spr_tag_entry: one tracked register (value, avail, producer tag) with a one-deep checkpoint.
//   alloc_valid/alloc_rs_id           - a younger writer was dispatched: go pending on its tag
//   update_valid/update_data/rs_id    - result broadcast, fills tracker and checkpoint on tag match
//   checkpoint                        - snapshot the post-alloc/update state
//   restore                           - roll the tracker back to the snapshot
//   rd_value/rd_avail/rd_tag          - pre-alloc state with same-cycle broadcast bypassed
module spr_tag_entry #(
    parameter int WIDTH = 32,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid,
    input  logic [RS_ID_WIDTH-1:0] alloc_rs_id,
    input  logic                   update_valid,
    input  logic [WIDTH-1:0]       update_data,
    input  logic [RS_ID_WIDTH-1:0] update_rs_id,
    input  logic                   checkpoint,
    input  logic                   restore,
    output logic [WIDTH-1:0]       rd_value,
    output logic                   rd_avail,
    output logic [RS_ID_WIDTH-1:0] rd_tag
);
    logic [WIDTH-1:0] value, ck_value, nxt_value, ck_nxt_value;
    logic avail, ck_avail, nxt_avail, ck_nxt_avail, hit, ck_hit;
    logic [RS_ID_WIDTH-1:0] tag, ck_tag, nxt_tag;
    always_comb begin
        hit = update_valid & ~avail & (update_rs_id == tag);
        ck_hit = update_valid & ~ck_avail & (update_rs_id == ck_tag);
        rd_value = hit ? update_data : value;
        rd_avail = avail | hit;
        rd_tag = tag;
        // a same-cycle alloc is younger than the broadcast, so it wins
        nxt_value = alloc_valid ? value : rd_value;
        nxt_avail = alloc_valid ? 1'b0 : rd_avail;
        nxt_tag = alloc_valid ? alloc_rs_id : tag;
        ck_nxt_value = ck_hit ? update_data : ck_value;
        ck_nxt_avail = ck_avail | ck_hit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            avail <= 1'b1;
            tag <= '0;
            ck_value <= '0;
            ck_avail <= 1'b1;
            ck_tag <= '0;
        end else begin
            value <= restore ? ck_nxt_value : nxt_value;
            avail <= restore ? ck_nxt_avail : nxt_avail;
            tag <= restore ? ck_tag : nxt_tag;
            ck_value <= checkpoint ? nxt_value : ck_nxt_value;
            ck_avail <= checkpoint ? nxt_avail : ck_nxt_avail;
            ck_tag <= checkpoint ? nxt_tag : ck_tag;
        end
    end
endmodule

// File: rtl/branch_issue_stage.sv
// branch_issue_stage: issues decoded branches to the predictor with CR/LR/CTR operands.
//   dec_*          - decode handshake, address and decoded fields
//   alloc_*        - younger non-branch writers of CR/LR/CTR dispatched this cycle
//   update_*       - result broadcasts (value + producer tag)
//   take_*         - one-entry output register handshake to the predictor
//   *_reg_out / *_valid_out / *_rs_id_out - operand value, availability, pending tag
//   speculative / clear_speculative / flush_speculative - one-level speculation control
module branch_issue_stage
    import ppc_types::*;
#(
    parameter int RS_ID_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [31:0]            dec_cia,
    input  branch_inner_decode_t   dec_control,
    input  logic                   alloc_cond_valid,
    input  logic [RS_ID_WIDTH-1:0] alloc_cond_rs_id,
    input  logic                   alloc_link_valid,
    input  logic [RS_ID_WIDTH-1:0] alloc_link_rs_id,
    input  logic                   alloc_count_valid,
    input  logic [RS_ID_WIDTH-1:0] alloc_count_rs_id,
    input  logic                   update_cond_reg_valid,
    input  logic [3:0]             update_cond_reg,
    input  logic [RS_ID_WIDTH-1:0] update_cond_reg_rs_id,
    input  logic                   update_link_reg_valid,
    input  logic [31:0]            update_link_reg,
    input  logic [RS_ID_WIDTH-1:0] update_link_reg_rs_id,
    input  logic                   update_count_reg_valid,
    input  logic [31:0]            update_count_reg,
    input  logic [RS_ID_WIDTH-1:0] update_count_reg_rs_id,
    output logic                   take_valid,
    input  logic                   take_ready,
    output logic [31:0]            cia_out,
    output branch_inner_decode_t   control_out,
    output logic [3:0]             cond_reg_out,
    output logic [31:0]            link_reg_out,
    output logic [31:0]            count_reg_out,
    output logic                   cond_reg_valid_out,
    output logic                   link_reg_valid_out,
    output logic                   count_reg_valid_out,
    output logic [RS_ID_WIDTH-1:0] cond_reg_rs_id_out,
    output logic [RS_ID_WIDTH-1:0] link_reg_rs_id_out,
    output logic [RS_ID_WIDTH-1:0] count_reg_rs_id_out,
    input  logic                   speculative,
    input  logic                   clear_speculative,
    input  logic                   flush_speculative
);
    logic spec_active, spec, load, take_ckpt, restore;
    logic cond_snoop, link_snoop, count_snoop;
    logic [3:0] cond_rd;
    logic [31:0] link_rd, count_rd;
    logic cond_av, link_av, count_av;
    logic [RS_ID_WIDTH-1:0] cond_tg, link_tg, count_tg;
    assign dec_ready = ~take_valid | take_ready;
    // a flush discards whatever decode hands over in the same cycle
    assign load = dec_valid & dec_ready & ~flush_speculative;
    assign take_ckpt = speculative & ~spec_active;
    assign restore = flush_speculative & spec_active;
    assign cond_snoop = take_valid & update_cond_reg_valid & ~cond_reg_valid_out & (update_cond_reg_rs_id == cond_reg_rs_id_out);
    assign link_snoop = take_valid & update_link_reg_valid & ~link_reg_valid_out & (update_link_reg_rs_id == link_reg_rs_id_out);
    assign count_snoop = take_valid & update_count_reg_valid & ~count_reg_valid_out & (update_count_reg_rs_id == count_reg_rs_id_out);
    spr_tag_entry #(.WIDTH(4), .RS_ID_WIDTH(RS_ID_WIDTH)) u_cond (
        .clk(clk), .rst(rst), .alloc_valid(alloc_cond_valid), .alloc_rs_id(alloc_cond_rs_id),
        .update_valid(update_cond_reg_valid), .update_data(update_cond_reg), .update_rs_id(update_cond_reg_rs_id),
        .checkpoint(take_ckpt), .restore(restore), .rd_value(cond_rd), .rd_avail(cond_av), .rd_tag(cond_tg)
    );
    spr_tag_entry #(.WIDTH(32), .RS_ID_WIDTH(RS_ID_WIDTH)) u_link (
        .clk(clk), .rst(rst), .alloc_valid(alloc_link_valid), .alloc_rs_id(alloc_link_rs_id),
        .update_valid(update_link_reg_valid), .update_data(update_link_reg), .update_rs_id(update_link_reg_rs_id),
        .checkpoint(take_ckpt), .restore(restore), .rd_value(link_rd), .rd_avail(link_av), .rd_tag(link_tg)
    );
    spr_tag_entry #(.WIDTH(32), .RS_ID_WIDTH(RS_ID_WIDTH)) u_count (
        .clk(clk), .rst(rst), .alloc_valid(alloc_count_valid), .alloc_rs_id(alloc_count_rs_id),
        .update_valid(update_count_reg_valid), .update_data(update_count_reg), .update_rs_id(update_count_reg_rs_id),
        .checkpoint(take_ckpt), .restore(restore), .rd_value(count_rd), .rd_avail(count_av), .rd_tag(count_tg)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_active <= 1'b0;
            spec <= 1'b0;
            take_valid <= 1'b0;
            cia_out <= '0;
            control_out <= '0;
            cond_reg_out <= '0;
            link_reg_out <= '0;
            count_reg_out <= '0;
            cond_reg_valid_out <= 1'b0;
            link_reg_valid_out <= 1'b0;
            count_reg_valid_out <= 1'b0;
            cond_reg_rs_id_out <= '0;
            link_reg_rs_id_out <= '0;
            count_reg_rs_id_out <= '0;
        end else begin
            spec_active <= (flush_speculative | clear_speculative) ? 1'b0 : (spec_active | speculative);
            if (load) begin
                take_valid <= 1'b1;
                spec <= ~clear_speculative & (spec_active | speculative);
                cia_out <= dec_cia;
                control_out <= dec_control;
                cond_reg_out <= cond_rd;
                link_reg_out <= link_rd;
                count_reg_out <= count_rd;
                cond_reg_valid_out <= cond_av;
                link_reg_valid_out <= link_av;
                count_reg_valid_out <= count_av;
                cond_reg_rs_id_out <= cond_tg;
                link_reg_rs_id_out <= link_tg;
                count_reg_rs_id_out <= count_tg;
            end else begin
                if (take_ready | (flush_speculative & spec)) take_valid <= 1'b0;
                if (clear_speculative) spec <= 1'b0;
                if (cond_snoop) begin
                    cond_reg_out <= update_cond_reg;
                    cond_reg_valid_out <= 1'b1;
                end
                if (link_snoop) begin
                    link_reg_out <= update_link_reg;
                    link_reg_valid_out <= 1'b1;
                end
                if (count_snoop) begin
                    count_reg_out <= update_count_reg;
                    count_reg_valid_out <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_issue_stage.sv
// tb_branch_issue_stage: scoreboard bench for branch_issue_stage with a queue-based reference model.
module tb_branch_issue_stage;
    import ppc_types::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, dec_valid, take_ready, speculative, clear_speculative, flush_speculative;
    logic [31:0] dec_cia;
    branch_inner_decode_t dec_control;
    logic [2:0] al_v, up_v;
    logic [2:0][4:0] al_t, up_t;
    logic [2:0][31:0] up_d;
    logic dec_ready, take_valid, cond_v, link_v, count_v;
    logic [31:0] cia_out, link_reg_out, count_reg_out;
    branch_inner_decode_t control_out;
    logic [3:0] cond_reg_out;
    logic [4:0] cond_t, link_t, count_t;
    branch_issue_stage #(.RS_ID_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_cia(dec_cia), .dec_control(dec_control),
        .alloc_cond_valid(al_v[0]), .alloc_cond_rs_id(al_t[0]),
        .alloc_link_valid(al_v[1]), .alloc_link_rs_id(al_t[1]),
        .alloc_count_valid(al_v[2]), .alloc_count_rs_id(al_t[2]),
        .update_cond_reg_valid(up_v[0]), .update_cond_reg(up_d[0][3:0]), .update_cond_reg_rs_id(up_t[0]),
        .update_link_reg_valid(up_v[1]), .update_link_reg(up_d[1]), .update_link_reg_rs_id(up_t[1]),
        .update_count_reg_valid(up_v[2]), .update_count_reg(up_d[2]), .update_count_reg_rs_id(up_t[2]),
        .take_valid(take_valid), .take_ready(take_ready), .cia_out(cia_out), .control_out(control_out),
        .cond_reg_out(cond_reg_out), .link_reg_out(link_reg_out), .count_reg_out(count_reg_out),
        .cond_reg_valid_out(cond_v), .link_reg_valid_out(link_v), .count_reg_valid_out(count_v),
        .cond_reg_rs_id_out(cond_t), .link_reg_rs_id_out(link_t), .count_reg_rs_id_out(count_t),
        .speculative(speculative), .clear_speculative(clear_speculative), .flush_speculative(flush_speculative)
    );
    typedef struct packed {
        logic [31:0] cia;
        branch_inner_decode_t ctl;
        logic [2:0][31:0] v;
        logic [2:0] a;
        logic [2:0][4:0] t;
        logic spec;
    } rec_t;
    rec_t q[$];
    rec_t e;
    logic [31:0] tv[3], cv[3];
    logic ta[3], ca[3];
    logic [4:0] tt[3], ct[3];
    bit spec_active;
    int checks = 0, errors = 0;
    bit go = 0;
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic idle();
        rst = 0; dec_valid = 0; dec_cia = 0; dec_control = '0;
        al_v = 0; al_t = '0; up_v = 0; up_d = '0; up_t = '0;
        take_ready = 1; speculative = 0; clear_speculative = 0; flush_speculative = 0;
    endtask
    task automatic br(logic [31:0] a);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        dec_valid = 1; dec_cia = a; dec_control = branch_inner_decode_t'(r[37:0]);
    endtask
    // Reference: each register is (value, available, waiting-on tag); branches in flight are a queue.
    task automatic model_edge(bit rdy);
        rec_t r;
        logic [2:0] hit;
        logic [31:0] nv[3];
        logic na[3];
        logic [4:0] nt[3];
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                tv[i] = 0; ta[i] = 1; tt[i] = 0; cv[i] = 0; ca[i] = 1; ct[i] = 0;
            end
            spec_active = 0;
            q.delete();
            return;
        end
        for (int i = 0; i < 3; i++) hit[i] = up_v[i] && !ta[i] && up_t[i] == tt[i];
        foreach (q[k])
            for (int i = 0; i < 3; i++)
                if (!q[k].a[i] && up_v[i] && up_t[i] == q[k].t[i]) begin
                    q[k].v[i] = up_d[i]; q[k].a[i] = 1;
                end
        if (flush_speculative)
            for (int k = q.size() - 1; k >= 0; k--) if (q[k].spec) q.delete(k);
        if (clear_speculative) foreach (q[k]) q[k].spec = 0;
        r.cia = dec_cia; r.ctl = dec_control;
        r.spec = !clear_speculative && (spec_active || speculative);
        for (int i = 0; i < 3; i++) begin
            r.v[i] = hit[i] ? up_d[i] : tv[i];
            r.a[i] = ta[i] || hit[i];
            r.t[i] = tt[i];
            nv[i] = al_v[i] ? tv[i] : r.v[i];
            na[i] = al_v[i] ? 1'b0 : r.a[i];
            nt[i] = al_v[i] ? al_t[i] : tt[i];
            if (up_v[i] && !ca[i] && up_t[i] == ct[i]) begin
                cv[i] = up_d[i]; ca[i] = 1;
            end
            if (speculative && !spec_active) begin
                cv[i] = nv[i]; ca[i] = na[i]; ct[i] = nt[i];
            end
            if (flush_speculative && spec_active) begin
                tv[i] = cv[i]; ta[i] = ca[i]; tt[i] = ct[i];
            end else begin
                tv[i] = nv[i]; ta[i] = na[i]; tt[i] = nt[i];
            end
        end
        spec_active = (flush_speculative || clear_speculative) ? 1'b0 : (spec_active || speculative);
        if (dec_valid && rdy && !flush_speculative) q.push_back(r);
    endtask
    task automatic step();
        bit rdy;
        rdy = q.size() == 0 || take_ready;
        @(posedge clk);
        #1;
        model_edge(rdy);
        idle();
    endtask
    initial begin
        wait (go);
        forever begin
            @(negedge clk);
            chk("take_valid", 64'(take_valid), 64'(q.size() != 0));
            chk("dec_ready", 64'(dec_ready), 64'(q.size() == 0 || take_ready));
            if (take_valid && take_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("cia_out", 64'(cia_out), 64'(e.cia));
                chk("control_out", 64'(control_out), 64'(e.ctl));
                chk("cond_reg_out", 64'(cond_reg_out), 64'(e.v[0][3:0]));
                chk("cond_valid", 64'(cond_v), 64'(e.a[0]));
                chk("cond_rs_id", 64'(cond_t), 64'(e.t[0]));
                chk("link_reg_out", 64'(link_reg_out), 64'(e.v[1]));
                chk("link_valid", 64'(link_v), 64'(e.a[1]));
                chk("link_rs_id", 64'(link_t), 64'(e.t[1]));
                chk("count_reg_out", 64'(count_reg_out), 64'(e.v[2]));
                chk("count_valid", 64'(count_v), 64'(e.a[2]));
                chk("count_rs_id", 64'(count_t), 64'(e.t[2]));
            end
        end
    end
    initial begin
        idle();
        rst = 1; step();
        rst = 1; step();
        @(negedge clk);
        chk("rst_take_valid", 64'(take_valid), 64'd0);
        chk("rst_dec_ready", 64'(dec_ready), 64'd1);
        chk("rst_cia_out", 64'(cia_out), 64'd0);
        chk("rst_link_out", 64'(link_reg_out), 64'd0);
        chk("rst_cond_valid", 64'(cond_v), 64'd0);
        chk("rst_count_rs_id", 64'(count_t), 64'd0);
        go = 1;
        // first branch after reset: all operands available, zero
        br(32'h100); step(); step();
        // pending LR filled while held
        al_v[1] = 1; al_t[1] = 5'd3; step();
        br(32'h104); step();
        take_ready = 0; step();
        take_ready = 0; up_v[1] = 1; up_d[1] = 32'h2000; up_t[1] = 5'd3; step();
        take_ready = 0; step();
        step();
        // wrong tag ignored; alloc beats same-cycle broadcast
        al_v[1] = 1; al_t[1] = 5'd3; step();
        up_v[1] = 1; up_d[1] = 32'h1111; up_t[1] = 5'd4; step();
        al_v[1] = 1; al_t[1] = 5'd5; up_v[1] = 1; up_d[1] = 32'h2222; up_t[1] = 5'd3; step();
        br(32'h200); step(); step();
        // speculation flushed: CTR alloc rolled back, speculative branch dropped
        speculative = 1; step();
        al_v[2] = 1; al_t[2] = 5'd7; step();
        br(32'h300); take_ready = 0; step();
        take_ready = 0; flush_speculative = 1; step();
        br(32'h304); step(); step();
        // fill under speculation survives clear; stray flush does nothing
        al_v[0] = 1; al_t[0] = 5'd2; step();
        speculative = 1; step();
        up_v[0] = 1; up_d[0] = 32'hA; up_t[0] = 5'd2; step();
        clear_speculative = 1; step();
        br(32'h310); step(); step();
        flush_speculative = 1; step();
        br(32'h314); step(); step();
        // backpressure holds the entry and stalls decode
        br(32'h400); step();
        take_ready = 0; br(32'h404); step();
        take_ready = 0; br(32'h404); step();
        br(32'h404); step(); step();
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 199) == 0;
            if ($urandom_range(0, 9) < 6) br($urandom());
            take_ready = $urandom_range(0, 9) < 7;
            for (int i = 0; i < 3; i++) begin
                al_v[i] = $urandom_range(0, 9) < 2;
                al_t[i] = 5'($urandom_range(0, 7));
                up_v[i] = $urandom_range(0, 9) < 4;
                up_t[i] = 5'($urandom_range(0, 7));
                up_d[i] = (i == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            end
            speculative = $urandom_range(0, 19) == 0;
            clear_speculative = $urandom_range(0, 29) == 0;
            flush_speculative = $urandom_range(0, 24) == 0;
            step();
        end
        repeat (4) step();
        @(negedge clk);
        chk("drain_queue", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_issue_stage.md
# branch_issue_stage

Transmitter side of the branch predictor's instruction-take interface. Accepts decoded branch instructions from decode and tracks the architectural value, availability and producing reservation-station ID of CR field, LR and CTR. Presents each branch with its operands (value + valid, or pending rs_id) through a one-entry output register. Snoops result broadcasts while holding an instruction, and checkpoints/restores the tracker around one level of speculation.

## Interface
- RS_ID_WIDTH, 5, width of reservation-station tags
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid / dec_ready  in/out  1  decode handshake
- dec_cia  in  32  instruction address
- dec_control  in  branch_inner_decode_t  decoded branch fields
- alloc_{cond,link,count}_valid  in  1  a younger non-branch writer of that register was dispatched this cycle
- alloc_{cond,link,count}_rs_id  in  RS_ID_WIDTH  tag of that writer
- update_cond_reg_valid / update_cond_reg / update_cond_reg_rs_id  in  1/4/RS_ID_WIDTH  result broadcast
- update_link_reg_valid / update_link_reg / update_link_reg_rs_id  in  1/32/RS_ID_WIDTH
- update_count_reg_valid / update_count_reg / update_count_reg_rs_id  in  1/32/RS_ID_WIDTH
- take_valid  out 1; take_ready  in 1  handshake to predictor
- cia_out  out 32; control_out  out branch_inner_decode_t
- cond_reg_out 4, link_reg_out 32, count_reg_out 32  out  operand values
- {cond,link,count}_reg_valid_out  out 1; {cond,link,count}_reg_rs_id_out  out RS_ID_WIDTH
- speculative, clear_speculative, flush_speculative  in  1  from predictor

## Operation
- Tracker, per register: value, avail bit, tag. Reset: value 0, avail 1, tag 0.
- alloc_X_valid: avail←0, tag←alloc rs_id. Broadcast with update_X_valid, !avail, matching tag: value←data, avail←1. Non-matching or already-avail broadcast ignored. Alloc and broadcast to same register in same cycle: alloc wins.
- Accept: dec_valid & dec_ready, dec_ready = !take_valid | take_ready. Output register loads cia, control, and per operand {value, avail, tag} read from tracker state before same-cycle alloc (branch older than same-cycle alloc) with bypass of a same-cycle matching broadcast.
- Held entry (take_valid & !take_ready) snoops broadcasts exactly like tracker: matching tag sets value and valid_out.
- Speculation, one level: speculative pulse while no checkpoint → copy tracker (after same-cycle alloc/update) into checkpoint, set spec_active. Pulse while spec_active ignored. Broadcasts also update matching checkpoint entries. clear_speculative → spec_active←0. flush_speculative → tracker←checkpoint, spec_active←0. Flush and clear together: flush wins.
- Output entry carries spec bit = spec_active | speculative at load. Flush drops entry with spec bit (take_valid←0) and discards same-cycle decode accept. Non-spec entry survives. Clear resets held spec bit.

## Timing
- Reset: take_valid 0, all data/valid/rs_id outputs 0, dec_ready 1, spec_active 0.
- Decode to take_valid: 1 cycle. Back-to-back throughput 1/cycle while take_ready high.
- Alloc visible to a branch accepted next cycle; broadcast bypassed same cycle.
- Outputs stable while take_valid & !take_ready except snooped operand fill.
- rst mid-operation: entry, tracker, checkpoint cleared next edge.

## Structure
- branch_inner_decode_t and operation enums from ppc_types; no new package types.
- Sub-module spr_tag_entry #(WIDTH, RS_ID_WIDTH): value/avail/tag register, alloc, snoop, bypassed read port, checkpoint/restore; instantiated for cond (4), link (32), count (32).

## Test plan
- Reset, dec_valid with cia 0x100 → next cycle take_valid 1, cia_out 0x100, all valid_out 1, values 0.
- alloc_link rs_id 3, then branch → link_reg_valid_out 0, rs_id_out 3; hold take_ready 0, broadcast LR 0x2000 tag 3 → link_reg_valid_out 1, link_reg_out 0x2000.
- Broadcast tag 4 to pending tag 3 → ignored; alloc tag 5 and broadcast tag 3 same cycle → tracker pending tag 5.
- speculative, then alloc_count tag 7, then flush → next branch sees count valid, original value; buffered speculative branch dropped.
- speculative, broadcast fills pending CR tag 2 with 0xA, clear_speculative → CR stays 0xA; later flush without new speculative has no effect.
- take_ready 0 with entry held, dec_valid 1 → dec_ready 0, entry unchanged until take_ready rises.
